// File: rtl/saus_pkg.sv
// saus_pkg: definitions shared across the SAUS input-selection path.
//   VEC_LEN      - entries in an assembled vector
//   size_code_t  - 2-bit transform size code (0=4, 1=8, 2=16, 3=32 samples)
//   sample_t     - default-width signed residual sample
//   fill_state_t - fill FSM state encoding of the vector collector
//   size_to_len  - number of samples for a size code (also used by t2s)
package saus_pkg;

    localparam int VEC_LEN  = 32;
    localparam int SAMPLE_W = 16;

    typedef logic [1:0] size_code_t;
    typedef logic signed [SAMPLE_W-1:0] sample_t;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_FILL = 2'd1,
        ST_FULL = 2'd2
    } fill_state_t;

    function automatic logic [5:0] size_to_len(input size_code_t code);
        return 6'd4 << code;
    endfunction

endpackage

// File: rtl/saus_vec_outreg.sv
// saus_vec_outreg: registered output stage of the vector collector.
// Loads a masked copy of the fill buffer and holds it until consumed.
//   clk, rst  - clock, synchronous active-high reset
//   i_load    - copy i_fill/i_size into the output register this edge
//   i_fill    - fill buffer contents (entries past the size may be stale)
//   i_size    - size code belonging to i_fill
//   i_ready   - downstream consumes the held vector
//   o_valid   - a complete vector is held
//   o_vector  - held vector, zero beyond the active length
//   o_size    - held size code
module saus_vec_outreg
    import saus_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           i_load,
    input  logic [VEC_LEN-1:0][WIDTH-1:0]  i_fill,
    input  size_code_t                     i_size,
    input  logic                           i_ready,
    output logic                           o_valid,
    output logic [VEC_LEN-1:0][WIDTH-1:0]  o_vector,
    output size_code_t                     o_size
);

    logic                          r_valid;
    logic [VEC_LEN-1:0][WIDTH-1:0] r_vector;
    size_code_t                    r_size;
    logic [5:0]                    w_len;

    assign w_len = size_to_len(i_size);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_valid  <= 1'b0;
            r_vector <= '0;
            r_size   <= '0;
        end else if (i_load) begin
            // Stale entries from earlier, larger vectors are masked here,
            // so the fill buffer never has to be cleared between vectors.
            for (int i = 0; i < VEC_LEN; i++) begin
                r_vector[i] <= (6'(i) < w_len) ? i_fill[i] : '0;
            end
            r_size  <= i_size;
            r_valid <= 1'b1;
        end else if (r_valid && i_ready) begin
            r_valid <= 1'b0;
        end
    end

    assign o_valid  = r_valid;
    assign o_vector = r_vector;
    assign o_size   = r_size;

endmodule

// File: rtl/saus_vector_collector.sv
// saus_vector_collector: gathers LANES-wide residual beats into a 32-entry
// vector for the t2s stage. Fill buffer plus output register form a double
// buffer, so the next vector fills while the current one waits downstream.
//   clk, rst            - clock, synchronous active-high reset
//   in_valid/in_ready   - input beat handshake (in_ready decoded from state)
//   in_data             - LANES samples; lane k goes to next index + k
//   in_size             - size code, sampled on the first beat of a vector
//   out_valid/out_ready - output vector handshake
//   out_vector          - assembled vector, index 0 = first sample
//   out_size            - size code of out_vector
//
// Fill FSM:
//   state   | meaning
//   IDLE    | no vector in progress, next beat starts a vector (in_ready=1)
//   FILL    | vector partly collected, in_size ignored (in_ready=1)
//   FULL    | vector complete, waiting for the output register (in_ready=0)
module saus_vector_collector
    import saus_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int LANES = 4
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           in_valid,
    output logic                           in_ready,
    input  logic [LANES-1:0][WIDTH-1:0]    in_data,
    input  logic [1:0]                     in_size,
    output logic                           out_valid,
    input  logic                           out_ready,
    output logic [VEC_LEN-1:0][WIDTH-1:0]  out_vector,
    output logic [1:0]                     out_size
);

    localparam logic [5:0] LANES_W = 6'(LANES);

    fill_state_t                   r_state;
    logic [5:0]                    r_wr_ptr;
    size_code_t                    r_fill_size;
    logic [VEC_LEN-1:0][WIDTH-1:0] r_fill;

    logic       w_accept;
    logic       w_last;
    logic       w_load;
    logic [5:0] w_base;
    logic [5:0] w_next_ptr;
    size_code_t w_size;

    // Held low while rst is asserted so no beat is taken in the reset cycle.
    assign in_ready   = (r_state != ST_FULL) && !rst;
    assign w_accept   = in_valid && in_ready;

    // A vector always starts at index 0 with the size offered on that beat.
    assign w_base     = (r_state == ST_IDLE) ? 6'd0 : r_wr_ptr;
    assign w_size     = (r_state == ST_IDLE) ? in_size : r_fill_size;
    assign w_next_ptr = w_base + LANES_W;
    assign w_last     = (w_next_ptr == size_to_len(w_size));

    // Output register is free, or is being emptied on this same edge.
    assign w_load     = (r_state == ST_FULL) && (!out_valid || out_ready);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= ST_IDLE;
            r_wr_ptr    <= '0;
            r_fill_size <= '0;
            r_fill      <= '0;
        end else begin
            case (r_state)
                ST_IDLE, ST_FILL: begin
                    if (w_accept) begin
                        for (int k = 0; k < LANES; k++) begin
                            r_fill[w_base[4:0] + 5'(k)] <= in_data[k];
                        end
                        r_wr_ptr <= w_next_ptr;
                        if (r_state == ST_IDLE) begin
                            r_fill_size <= in_size;
                        end
                        r_state <= w_last ? ST_FULL : ST_FILL;
                    end
                end
                ST_FULL: begin
                    if (w_load) begin
                        r_state <= ST_IDLE;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    saus_vec_outreg #(
        .WIDTH (WIDTH)
    ) u_outreg (
        .clk      (clk),
        .rst      (rst),
        .i_load   (w_load),
        .i_fill   (r_fill),
        .i_size   (r_fill_size),
        .i_ready  (out_ready),
        .o_valid  (out_valid),
        .o_vector (out_vector),
        .o_size   (out_size)
    );

endmodule

// File: tb/tb_saus_vector_collector.sv
// Testbench for saus_vector_collector: directed scenarios plus a randomized
// run checked against a queue-based reference of whole vectors.
module tb_saus_vector_collector;

    localparam int WIDTH  = 16;
    localparam int LANES  = 4;
    localparam int VL     = 32;
    localparam int BUDGET = 60000;

    typedef logic [VL-1:0][WIDTH-1:0] vec_t;
    typedef struct {
        vec_t       v;
        logic [1:0] s;
    } exp_t;

    logic                        clk = 1'b0;
    logic                        rst = 1'b1;
    logic                        in_valid = 1'b0;
    logic                        in_ready;
    logic [LANES-1:0][WIDTH-1:0] in_data = '0;
    logic [1:0]                  in_size = 2'd0;
    logic                        out_valid;
    logic                        out_ready = 1'b0;
    vec_t                        out_vector;
    logic [1:0]                  out_size;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    saus_vector_collector #(
        .WIDTH (WIDTH),
        .LANES (LANES)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_data    (in_data),
        .in_size    (in_size),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_vector (out_vector),
        .out_size   (out_size)
    );

    // Reference vector: sample i = first + step*i for i < len, zero beyond.
    function automatic vec_t make_vec(input int first, input int step, input int len);
        vec_t v;
        v = '0;
        for (int i = 0; i < len; i++) v[i] = WIDTH'(first + step * i);
        return v;
    endfunction

    // Drives the first len samples of smp as consecutive beats, one per cycle.
    task automatic send_vec(input vec_t smp, input int len, input logic [1:0] sz,
                            input logic [1:0] later_sz);
        for (int b = 0; b < len / LANES; b++) begin
            in_valid = 1'b1;
            in_size  = (b == 0) ? sz : later_sz;
            for (int k = 0; k < LANES; k++) in_data[k] = smp[b * LANES + k];
            @(negedge clk);
        end
        in_valid = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) @(negedge clk);
        tests++; if (in_ready !== 1'b0) begin fails++; $display("FAIL reset_in_ready got %b want 0", in_ready); end
        tests++; if (out_valid !== 1'b0) begin fails++; $display("FAIL reset_out_valid got %b want 0", out_valid); end
        tests++; if (out_size !== 2'd0) begin fails++; $display("FAIL reset_out_size got %0d want 0", out_size); end
        tests++; if (out_vector !== '0) begin fails++; $display("FAIL reset_out_vector got %h want 0", out_vector); end
        rst = 1'b0;
        #1;
        tests++; if (in_ready !== 1'b1) begin fails++; $display("FAIL idle_in_ready got %b want 1", in_ready); end
        @(negedge clk);
    endtask

    task automatic test_full32();
        vec_t e;
        e = make_vec(1, 1, 32);
        out_ready = 1'b1;
        send_vec(e, 32, 2'd3, 2'd3);
        tests++; if (out_valid !== 1'b0) begin fails++; $display("FAIL full32_early_valid got %b want 0", out_valid); end
        tests++; if (in_ready !== 1'b0) begin fails++; $display("FAIL full32_full_in_ready got %b want 0", in_ready); end
        @(negedge clk);
        tests++; if (out_valid !== 1'b1) begin fails++; $display("FAIL full32_valid got %b want 1", out_valid); end
        tests++; if (out_vector !== e) begin fails++; $display("FAIL full32_vector got %h want %h", out_vector, e); end
        tests++; if (out_size !== 2'd3) begin fails++; $display("FAIL full32_size got %0d want 3", out_size); end
        @(negedge clk);
        tests++; if (out_valid !== 1'b0) begin fails++; $display("FAIL full32_valid_one_cycle got %b want 0", out_valid); end
        tests++; if (in_ready !== 1'b1) begin fails++; $display("FAIL full32_back_idle got %b want 1", in_ready); end
    endtask

    task automatic test_small_sizes();
        vec_t a, b;
        a = '0;
        a[0] = WIDTH'(-1); a[1] = WIDTH'(2); a[2] = WIDTH'(-3); a[3] = WIDTH'(4);
        b = make_vec(50, 1, 8);
        out_ready = 1'b1;
        send_vec(a, 4, 2'd0, 2'd0);
        @(negedge clk);
        tests++; if (out_vector !== a) begin fails++; $display("FAIL size0_vector got %h want %h", out_vector, a); end
        tests++; if (out_size !== 2'd0) begin fails++; $display("FAIL size0_size got %0d want 0", out_size); end
        tests++; if (in_ready !== 1'b1) begin fails++; $display("FAIL size0_no_stall got %b want 1", in_ready); end
        send_vec(b, 8, 2'd1, 2'd1);
        @(negedge clk);
        tests++; if (out_valid !== 1'b1) begin fails++; $display("FAIL size1_valid got %b want 1", out_valid); end
        tests++; if (out_vector !== b) begin fails++; $display("FAIL size1_vector got %h want %h", out_vector, b); end
        tests++; if (out_size !== 2'd1) begin fails++; $display("FAIL size1_size got %0d want 1", out_size); end
        @(negedge clk);
    endtask

    task automatic test_backpressure();
        vec_t a, b;
        a = make_vec(100, 1, 16);
        b = make_vec(200, 1, 16);
        out_ready = 1'b0;
        send_vec(a, 16, 2'd2, 2'd2);
        @(negedge clk);
        send_vec(b, 16, 2'd2, 2'd2);
        repeat (3) @(negedge clk);
        tests++; if (out_valid !== 1'b1) begin fails++; $display("FAIL bp_hold_valid got %b want 1", out_valid); end
        tests++; if (out_vector !== a) begin fails++; $display("FAIL bp_hold_vector got %h want %h", out_vector, a); end
        tests++; if (out_size !== 2'd2) begin fails++; $display("FAIL bp_hold_size got %0d want 2", out_size); end
        tests++; if (in_ready !== 1'b0) begin fails++; $display("FAIL bp_full_in_ready got %b want 0", in_ready); end
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        tests++; if (out_valid !== 1'b1) begin fails++; $display("FAIL bp_swap_valid got %b want 1", out_valid); end
        tests++; if (out_vector !== b) begin fails++; $display("FAIL bp_swap_vector got %h want %h", out_vector, b); end
        tests++; if (in_ready !== 1'b1) begin fails++; $display("FAIL bp_swap_in_ready got %b want 1", in_ready); end
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        tests++; if (out_valid !== 1'b0) begin fails++; $display("FAIL bp_drain_valid got %b want 0", out_valid); end
    endtask

    task automatic test_size_change();
        vec_t c;
        c = make_vec(300, 1, 16);
        out_ready = 1'b0;
        send_vec(c, 16, 2'd2, 2'd0);
        tests++; if (in_ready !== 1'b0) begin fails++; $display("FAIL szchg_full got %b want 0", in_ready); end
        @(negedge clk);
        tests++; if (out_valid !== 1'b1) begin fails++; $display("FAIL szchg_valid got %b want 1", out_valid); end
        tests++; if (out_size !== 2'd2) begin fails++; $display("FAIL szchg_size got %0d want 2", out_size); end
        tests++; if (out_vector !== c) begin fails++; $display("FAIL szchg_vector got %h want %h", out_vector, c); end
    endtask

    task automatic test_mid_reset();
        vec_t d;
        d = make_vec(10, 10, 8);
        tests++; if (out_valid !== 1'b1) begin fails++; $display("FAIL mrst_pre_valid got %b want 1", out_valid); end
        for (int b = 0; b < 3; b++) begin
            in_valid = 1'b1;
            in_size  = (b == 0) ? 2'd3 : 2'd1;
            for (int k = 0; k < LANES; k++) in_data[k] = WIDTH'(400 + b * LANES + k);
            @(negedge clk);
        end
        rst = 1'b1;
        in_size = 2'd0;
        @(posedge clk);
        #1;
        tests++; if (out_valid !== 1'b0) begin fails++; $display("FAIL mrst_out_valid got %b want 0", out_valid); end
        tests++; if (in_ready !== 1'b0) begin fails++; $display("FAIL mrst_in_ready got %b want 0", in_ready); end
        @(negedge clk);
        rst = 1'b0;
        in_valid = 1'b0;
        out_ready = 1'b1;
        send_vec(d, 8, 2'd1, 2'd1);
        @(negedge clk);
        tests++; if (out_valid !== 1'b1) begin fails++; $display("FAIL mrst_new_valid got %b want 1", out_valid); end
        tests++; if (out_vector !== d) begin fails++; $display("FAIL mrst_new_vector got %h want %h", out_vector, d); end
        tests++; if (out_size !== 2'd1) begin fails++; $display("FAIL mrst_new_size got %0d want 1", out_size); end
        @(negedge clk);
        out_ready = 1'b0;
    endtask

    task automatic test_random(input int n);
        exp_t       q[$];
        exp_t       e;
        vec_t       cur;
        vec_t       held_v;
        logic [1:0] held_s;
        logic [1:0] cur_size;
        logic       have_cur;
        logic       stalled;
        int         cur_beats, beat, sent, consumed, cyc;
        have_cur = 1'b0; stalled = 1'b0;
        beat = 0; sent = 0; consumed = 0; cyc = 0; cur_beats = 1;
        cur = '0; cur_size = '0; held_v = '0; held_s = '0;
        while (consumed < n && cyc < BUDGET) begin
            if (stalled) begin
                tests++;
                if (out_valid !== 1'b1 || out_vector !== held_v || out_size !== held_s) begin
                    fails++;
                    $display("FAIL rnd_hold cyc %0d got v=%b s=%0d %h want v=1 s=%0d %h",
                             cyc, out_valid, out_size, out_vector, held_s, held_v);
                end
            end
            if (!have_cur && sent < n) begin
                cur_size  = 2'($urandom_range(0, 3));
                cur_beats = (4 << cur_size) / LANES;
                cur = '0;
                for (int i = 0; i < (4 << cur_size); i++) cur[i] = WIDTH'($urandom);
                e.v = cur; e.s = cur_size;
                q.push_back(e);
                have_cur = 1'b1;
            end
            in_valid = have_cur && ($urandom_range(0, 99) < 75);
            in_size  = (beat == 0) ? cur_size : 2'($urandom_range(0, 3));
            for (int k = 0; k < LANES; k++) in_data[k] = cur[(beat * LANES + k) % VL];
            out_ready = ($urandom_range(0, 99) < 70);
            #1;
            if (in_valid && in_ready) begin
                beat++;
                if (beat == cur_beats) begin
                    beat = 0; sent++; have_cur = 1'b0;
                end
            end
            if (out_valid && out_ready) begin
                tests++;
                if (q.size() == 0) begin
                    fails++;
                    $display("FAIL rnd_extra_vector got %h want none", out_vector);
                end else begin
                    e = q.pop_front();
                    if (out_vector !== e.v || out_size !== e.s) begin
                        fails++;
                        $display("FAIL rnd_vector %0d got s=%0d %h want s=%0d %h",
                                 consumed, out_size, out_vector, e.s, e.v);
                    end
                end
                consumed++;
            end
            stalled = out_valid && !out_ready;
            held_v  = out_vector;
            held_s  = out_size;
            @(negedge clk);
            cyc++;
        end
        in_valid = 1'b0;
        out_ready = 1'b0;
        tests++; if (consumed != n) begin fails++; $display("FAIL rnd_count got %0d want %0d", consumed, n); end
        tests++; if (q.size() != 0) begin fails++; $display("FAIL rnd_leftover got %0d want 0", q.size()); end
    endtask

    initial begin
        @(negedge clk);
        test_reset();
        test_full32();
        test_small_sizes();
        test_backpressure();
        test_size_change();
        test_mid_reset();
        test_random(1000);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
